// File: rtl/super_tile_pkg.sv
// rtl/super_tile_pkg.sv - shared FSM state type and default sizing for the super-tile frame loader
package super_tile_pkg;

    localparam int DEF_NUM_SUBTILES       = 2;
    localparam int DEF_FRAME_BITS_PER_ROW = 32;
    localparam int DEF_MAX_FRAMES_PER_COL = 20;
    localparam int DEF_CFG_BITS           = 416;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

endpackage

// File: rtl/subtile_cfg_bank.sv
// rtl/subtile_cfg_bank.sv - one sub-tile's shadow/active configuration registers and dirty flag
module subtile_cfg_bank
    import super_tile_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS_PER_ROW,
    parameter int CFG_BITS   = DEF_CFG_BITS,
    parameter int IW         = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [FRAME_BITS-1:0] wr_data,
    input  logic                  commit_en,
    output logic [CFG_BITS-1:0]   active
);

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shadow_next;
    logic                dirty;

    // Merge the incoming frame into the shadow image; bits past CFG_BITS simply have no home.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < CFG_BITS; i++) begin
            if (wr_idx == IW'(i / FRAME_BITS)) begin
                shadow_next[i] = wr_data[i % FRAME_BITS];
            end
        end
    end

    // Shadow capture on write; shadow-to-active copy only when something changed since the last commit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow <= '0;
            active <= '0;
            dirty  <= 1'b0;
        end else if (commit_en) begin
            if (dirty) begin
                active <= shadow;
                dirty  <= 1'b0;
            end
        end else if (wr_en) begin
            shadow <= shadow_next;
            dirty  <= 1'b1;
        end
    end

endmodule

// File: rtl/super_tile_frame_loader.sv
// rtl/super_tile_frame_loader.sv - frame-addressed config loader with staged commit; optional readback via SUPER_TILE_READBACK_EN
module super_tile_frame_loader
    import super_tile_pkg::*;
#(
    parameter int NUM_SUBTILES    = DEF_NUM_SUBTILES,
    parameter int FrameBitsPerRow = DEF_FRAME_BITS_PER_ROW,
    parameter int MaxFramesPerCol = DEF_MAX_FRAMES_PER_COL,
    parameter int CFG_BITS        = DEF_CFG_BITS,
    localparam int RW = (NUM_SUBTILES > 1) ? $clog2(NUM_SUBTILES) : 1,
    localparam int IW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                             UserCLK,
    input  logic                             RESET_n,
    input  logic                             frm_valid,
    output logic                             frm_ready,
    input  logic [RW-1:0]                    frm_row,
    input  logic [IW-1:0]                    frm_idx,
    input  logic [FrameBitsPerRow-1:0]       frm_data,
    input  logic                             commit,
    output logic                             busy,
    output logic                             err,
`ifdef SUPER_TILE_READBACK_EN
    input  logic                             rb_req,
    input  logic [RW-1:0]                    rb_row,
    input  logic [IW-1:0]                    rb_idx,
    output logic [FrameBitsPerRow-1:0]       rb_data,
`endif
    output logic [NUM_SUBTILES*CFG_BITS-1:0] cfg_active
);

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] cnt_q;
    logic          accept;
    logic          row_ok;
    logic          idx_ok;
    logic          above_cfg;
    logic          wr_ok;

    logic [NUM_SUBTILES-1:0][CFG_BITS-1:0] act_rows;

    assign accept    = frm_valid && frm_ready;
    assign row_ok    = 32'(frm_row) < NUM_SUBTILES;
    assign idx_ok    = 32'(frm_idx) < MaxFramesPerCol;
    assign above_cfg = (32'(frm_idx) * FrameBitsPerRow) >= CFG_BITS;
    assign wr_ok     = accept && row_ok && idx_ok && !above_cfg;

    // Next-state and handshake outputs; commit requests seen while committing are dropped.
    always_comb begin
        state_d   = state_q;
        frm_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                frm_ready = 1'b1;
                if (commit) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy = 1'b1;
                if (cnt_q == RW'(NUM_SUBTILES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the sub-tile walk counter used during COMMIT.
    always_ff @(posedge UserCLK) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == COMMIT) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Sticky flag for writes addressed outside the sub-tile/frame grid.
    always_ff @(posedge UserCLK) begin
        if (!RESET_n) begin
            err <= 1'b0;
        end else if (accept && !(row_ok && idx_ok)) begin
            err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_SUBTILES; k++) begin : g_bank
        subtile_cfg_bank #(
            .FRAME_BITS (FrameBitsPerRow),
            .CFG_BITS   (CFG_BITS),
            .IW         (IW)
        ) u_bank (
            .clk       (UserCLK),
            .resetn    (RESET_n),
            .wr_en     (wr_ok && (frm_row == RW'(k))),
            .wr_idx    (frm_idx),
            .wr_data   (frm_data),
            .commit_en ((state_q == COMMIT) && (cnt_q == RW'(k))),
            .active    (act_rows[k])
        );
    end

    assign cfg_active = act_rows;

`ifdef SUPER_TILE_READBACK_EN
    logic [CFG_BITS-1:0]        rb_row_vec;
    logic [FrameBitsPerRow-1:0] rb_next;

    // Select the requested active frame; unmapped bits and out-of-range addresses read as zero.
    always_comb begin
        rb_row_vec = '0;
        rb_next    = '0;
        if (32'(rb_row) < NUM_SUBTILES) begin
            rb_row_vec = act_rows[rb_row];
        end
        for (int i = 0; i < CFG_BITS; i++) begin
            if (rb_idx == IW'(i / FrameBitsPerRow)) begin
                rb_next[i % FrameBitsPerRow] = rb_row_vec[i];
            end
        end
    end

    // Readback data register, updated one cycle after each request.
    always_ff @(posedge UserCLK) begin
        if (!RESET_n) begin
            rb_data <= '0;
        end else if (rb_req) begin
            rb_data <= rb_next;
        end
    end
`endif

endmodule

// File: tb/tb_super_tile_frame_loader.sv
// tb/tb_super_tile_frame_loader.sv - directed self-checking bench for super_tile_frame_loader
module tb_super_tile_frame_loader;

    localparam int N   = 2;
    localparam int FB  = 32;
    localparam int CFG = 416;
    localparam int AW  = N * CFG;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frm_valid;
    logic          frm_ready;
    logic [0:0]    frm_row;
    logic [4:0]    frm_idx;
    logic [FB-1:0] frm_data;
    logic          commit;
    logic          busy;
    logic          err;
    logic [AW-1:0] cfg_active;
    logic [AW-1:0] exp_act;
`ifdef SUPER_TILE_READBACK_EN
    logic          rb_req;
    logic [0:0]    rb_row;
    logic [4:0]    rb_idx;
    logic [FB-1:0] rb_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    super_tile_frame_loader dut (
        .UserCLK    (clk),
        .RESET_n    (rst_n),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_row    (frm_row),
        .frm_idx    (frm_idx),
        .frm_data   (frm_data),
        .commit     (commit),
        .busy       (busy),
        .err        (err),
`ifdef SUPER_TILE_READBACK_EN
        .rb_req     (rb_req),
        .rb_row     (rb_row),
        .rb_idx     (rb_idx),
        .rb_data    (rb_data),
`endif
        .cfg_active (cfg_active)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic wr(input logic [0:0] row, input logic [4:0] idx, input logic [FB-1:0] data);
        frm_valid = 1'b1;
        frm_row   = row;
        frm_idx   = idx;
        frm_data  = data;
        step();
        frm_valid = 1'b0;
    endtask

    task automatic do_commit(input string tag);
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk({tag, "_busy_c0"}, AW'(busy), AW'(1));
        step();
        chk({tag, "_busy_c1"}, AW'(busy), AW'(1));
        step();
        chk({tag, "_busy_done"}, AW'(busy), AW'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        frm_valid = 1'b0;
        frm_row   = '0;
        frm_idx   = '0;
        frm_data  = '0;
        commit    = 1'b0;
`ifdef SUPER_TILE_READBACK_EN
        rb_req    = 1'b0;
        rb_row    = '0;
        rb_idx    = '0;
`endif
        exp_act   = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_active", cfg_active, '0);
        chk("rst_busy", AW'(busy), AW'(0));
        chk("rst_ready", AW'(frm_ready), AW'(1));
        chk("rst_err", AW'(err), AW'(0));

        // Row 0 frame 0, commit, two busy cycles.
        wr(1'b0, 5'd0, 32'hDEADBEEF);
        chk("wr0_not_active_yet", cfg_active, '0);
        do_commit("c1");
        exp_act[31:0] = 32'hDEADBEEF;
        chk("c1_active", cfg_active, exp_act);

        // Row 1 last mapped frame plus a frame wholly above CFG_BITS; only row 1 dirty.
        wr(1'b1, 5'd12, 32'hFFFFFFFF);
        wr(1'b1, 5'd15, 32'h13579BDF);
        chk("above_cfg_no_err", AW'(err), AW'(0));
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        chk("c2_row1_not_yet", cfg_active, exp_act);
        step();
        exp_act[CFG + 384 +: 32] = 32'hFFFFFFFF;
        chk("c2_row1_updated", cfg_active, exp_act);
        chk("c2_busy_done", AW'(busy), AW'(0));

        // Writes and a second commit during COMMIT are refused / ignored.
        wr(1'b0, 5'd1, 32'hAAAA5555);
        commit = 1'b1;
        step();
        frm_valid = 1'b1;
        frm_row   = 1'b1;
        frm_idx   = 5'd0;
        frm_data  = 32'h12345678;
        #1;
        chk("commit_ready_low", AW'(frm_ready), AW'(0));
        step();
        chk("c3_busy_c1", AW'(busy), AW'(1));
        step();
        frm_valid = 1'b0;
        commit    = 1'b0;
        chk("c3_busy_done", AW'(busy), AW'(0));
        step();
        chk("c3_not_requeued", AW'(busy), AW'(0));
        exp_act[63:32] = 32'hAAAA5555;
        chk("c3_active", cfg_active, exp_act);
        do_commit("c4");
        chk("c4_no_stray_write", cfg_active, exp_act);

        // Out-of-range frame index: sticky err, nothing stored.
        wr(1'b0, 5'd20, 32'hCAFEF00D);
        chk("oor_err", AW'(err), AW'(1));
        do_commit("c5");
        chk("oor_active_same", cfg_active, exp_act);
        chk("oor_err_sticky", AW'(err), AW'(1));

`ifdef SUPER_TILE_READBACK_EN
        rb_req = 1'b1;
        rb_row = 1'b0;
        rb_idx = 5'd1;
        step();
        rb_req = 1'b0;
        chk("rb_row0_idx1", AW'(rb_data), AW'(32'hAAAA5555));
        rb_req = 1'b1;
        rb_row = 1'b1;
        rb_idx = 5'd13;
        step();
        rb_req = 1'b0;
        chk("rb_above_cfg", AW'(rb_data), AW'(0));
`endif

        // Reset in the second COMMIT cycle wipes everything.
        wr(1'b1, 5'd0, 32'h55AA55AA);
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_act = '0;
        chk("rc_active", cfg_active, exp_act);
        chk("rc_busy", AW'(busy), AW'(0));
        chk("rc_ready", AW'(frm_ready), AW'(1));
        chk("rc_err", AW'(err), AW'(0));
        do_commit("c6");
        chk("rc_shadow_cleared", cfg_active, exp_act);

`ifdef SUPER_TILE_READBACK_EN
        chk("rb_reset", AW'(rb_data), AW'(0));
        wr(1'b0, 5'd0, 32'h0BADF00D);
        do_commit("c7");
        rb_req = 1'b1;
        rb_row = 1'b0;
        rb_idx = 5'd0;
        step();
        rb_req = 1'b0;
        chk("rb_row0_idx0", AW'(rb_data), AW'(32'h0BADF00D));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
